// File: rtl/fc_mac_sequencer.sv
// rtl/fc_mac_sequencer.sv - single-MAC sequencer for one fully connected layer
// Walks the flattened input once per output channel and streams one saturated result per channel.
module fc_mac_sequencer #(
  parameter int INPUT_SIZE      = 5,
  parameter int INPUT_CHANNELS  = 3,
  parameter int OUTPUT_CHANNELS = 3,
  parameter int PX_SIZE         = 8,
  parameter int RELU            = 0,
  localparam int N  = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int WW = (N * OUTPUT_CHANNELS > 1) ? $clog2(N * OUTPUT_CHANNELS) : 1,
  localparam int CW = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      px_addr,
  input  logic [PX_SIZE-1:0] px_data,
  output logic [WW-1:0]      wt_addr,
  input  logic [PX_SIZE-1:0] wt_data,
  output logic [CW-1:0]      bias_addr,
  input  logic [PX_SIZE-1:0] bias_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PX_SIZE-1:0] out_data,
  output logic [CW-1:0]      out_chan
);

  localparam int ACC_SIZE = 2 * PX_SIZE + AW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [ACC_SIZE-1:0] MAXV =
    {{(ACC_SIZE-PX_SIZE+1){1'b0}}, {(PX_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] MINV =
    {{(ACC_SIZE-PX_SIZE+1){1'b1}}, {(PX_SIZE-1){1'b0}}};

  logic [2:0]                 state;
  logic [AW-1:0]              k;
  logic [CW-1:0]              c;
  logic [WW-1:0]              wt_addr_r;
  logic                       vld;
  logic signed [ACC_SIZE-1:0] acc;
  logic [PX_SIZE-1:0]         out_data_r;

  logic signed [2*PX_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0]  prod_ext;
  logic signed [ACC_SIZE-1:0]  bias_ext;
  logic signed [ACC_SIZE-1:0]  acc_next;
  logic signed [ACC_SIZE-1:0]  res;
  logic [PX_SIZE-1:0]          sat;

  assign prod     = $signed(px_data) * $signed(wt_data);
  assign prod_ext = {{(ACC_SIZE-2*PX_SIZE){prod[2*PX_SIZE-1]}}, prod};
  assign bias_ext = {{(ACC_SIZE-PX_SIZE){bias_data[PX_SIZE-1]}}, bias_data};
  // The last product lands while in FLUSH, so bias is folded into that same add.
  assign acc_next = acc + prod_ext + ((state == S_FLUSH) ? bias_ext : '0);

  always_comb begin
    res = acc;
    if (RELU != 0 && res[ACC_SIZE-1]) res = '0;
    if (res > MAXV)      sat = MAXV[PX_SIZE-1:0];
    else if (res < MINV) sat = MINV[PX_SIZE-1:0];
    else                 sat = res[PX_SIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k          <= '0;
      c          <= '0;
      wt_addr_r  <= '0;
      vld        <= 1'b0;
      acc        <= '0;
      out_data_r <= '0;
    end else begin
      // Read data trails the address by one cycle.
      vld <= (state == S_ISSUE);
      if (vld) acc <= acc_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ISSUE;
            k         <= '0;
            c         <= '0;
            wt_addr_r <= '0;
            acc       <= '0;
          end
        end
        S_ISSUE: begin
          if (k == AW'(N - 1)) begin
            state <= S_FLUSH;
          end else begin
            k         <= k + AW'(1);
            wt_addr_r <= wt_addr_r + WW'(1);
          end
        end
        S_FLUSH: begin
          if (!vld) begin
            out_data_r <= sat;
            state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (c == CW'(OUTPUT_CHANNELS - 1)) begin
              state <= S_DONE;
            end else begin
              // Weights are laid out channel-major, so the next channel is just the next word.
              c         <= c + CW'(1);
              k         <= '0;
              wt_addr_r <= wt_addr_r + WW'(1);
              acc       <= '0;
              state     <= S_ISSUE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign out_valid = (state == S_EMIT);
  assign px_addr   = k;
  assign wt_addr   = wt_addr_r;
  assign bias_addr = c;
  assign out_chan  = c;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// tb/tb_fc_mac_sequencer.sv - directed bench for fc_mac_sequencer (2x2x1 input, 2 channels)
module tb_fc_mac_sequencer;

  logic clk = 1'b0;
  logic rst, start, out_ready;

  logic       busy0, done0, out_valid0;
  logic [1:0] px_addr0;
  logic [2:0] wt_addr0;
  logic [0:0] bias_addr0, out_chan0;
  logic [7:0] px_data0, wt_data0, bias_data0, out_data0;

  logic       busy1, done1, out_valid1;
  logic [1:0] px_addr1;
  logic [2:0] wt_addr1;
  logic [0:0] bias_addr1, out_chan1;
  logic [7:0] px_data1, wt_data1, bias_data1, out_data1;

  logic [7:0] px_mem [0:3];
  logic [7:0] wt_mem [0:7];
  logic [7:0] bias_mem [0:1];

  int tests_run = 0;
  int tests_failed = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  fc_mac_sequencer #(.INPUT_SIZE(2), .INPUT_CHANNELS(1), .OUTPUT_CHANNELS(2),
                     .PX_SIZE(8), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .px_addr(px_addr0), .px_data(px_data0), .wt_addr(wt_addr0), .wt_data(wt_data0),
    .bias_addr(bias_addr0), .bias_data(bias_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_chan(out_chan0));

  fc_mac_sequencer #(.INPUT_SIZE(2), .INPUT_CHANNELS(1), .OUTPUT_CHANNELS(2),
                     .PX_SIZE(8), .RELU(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .px_addr(px_addr1), .px_data(px_data1), .wt_addr(wt_addr1), .wt_data(wt_data1),
    .bias_addr(bias_addr1), .bias_data(bias_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_chan(out_chan1));

  always @(posedge clk) begin
    px_data0   <= px_mem[px_addr0];
    wt_data0   <= wt_mem[wt_addr0];
    bias_data0 <= bias_mem[bias_addr0];
    px_data1   <= px_mem[px_addr1];
    wt_data1   <= wt_mem[wt_addr1];
    bias_data1 <= bias_mem[bias_addr1];
    if (!rst && out_valid0 && out_ready) hs_count <= hs_count + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int p0, p1, p2, p3,
                      input int w0, w1, w2, w3, w4, w5, w6, w7,
                      input int b0, b1);
    px_mem[0] = 8'(p0); px_mem[1] = 8'(p1); px_mem[2] = 8'(p2); px_mem[3] = 8'(p3);
    wt_mem[0] = 8'(w0); wt_mem[1] = 8'(w1); wt_mem[2] = 8'(w2); wt_mem[3] = 8'(w3);
    wt_mem[4] = 8'(w4); wt_mem[5] = 8'(w5); wt_mem[6] = 8'(w6); wt_mem[7] = 8'(w7);
    bias_mem[0] = 8'(b0); bias_mem[1] = 8'(b1);
  endtask

  // e*: RELU=0 results, r*: RELU=1 results
  task automatic run_pass(input int e0, input int e1, input int r0, input int r1,
                          input int stall, input bit glitch);
    int base;
    int exp_d, exp_r;
    base = hs_count;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      exp_d = (ch == 0) ? e0 : e1;
      exp_r = (ch == 0) ? r0 : r1;
      for (int i = 0; i < 4; i++) begin
        start = 1'b0;
        check("wt_addr", int'(wt_addr0), ch * 4 + i);
        check("px_addr", int'(px_addr0), i);
        check("bias_addr", int'(bias_addr0), ch);
        check("busy_issue", int'(busy0), 1);
        if (glitch && ch == 0 && i == 1) start = 1'b1;
        tick();
      end
      start = 1'b0;
      check("valid_early_a", int'(out_valid0), 0);
      tick();
      check("valid_early_b", int'(out_valid0), 0);
      tick();
      check("valid", int'(out_valid0), 1);
      check("out_data", int'($signed(out_data0)), exp_d);
      check("out_chan", int'(out_chan0), ch);
      check("out_data_relu", int'($signed(out_data1)), exp_r);
      if (ch == 0 && stall > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick();
          check("stall_valid", int'(out_valid0), 1);
          check("stall_data", int'($signed(out_data0)), exp_d);
          check("stall_chan", int'(out_chan0), 0);
          check("stall_wt_addr", int'(wt_addr0), 3);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    check("done_pulse", int'(done0), 1);
    check("busy_done", int'(busy0), 1);
    tick();
    check("done_clear", int'(done0), 0);
    check("busy_idle", int'(busy0), 0);
    check("results", hs_count - base, 2);
    repeat (8) tick();
    check("no_extra", hs_count - base, 2);
    check("idle_valid", int'(out_valid0), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    load(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_valid", int'(out_valid0), 0);
    check("rst_px_addr", int'(px_addr0), 0);
    check("rst_wt_addr", int'(wt_addr0), 0);
    check("rst_bias_addr", int'(bias_addr0), 0);
    check("rst_out_data", int'(out_data0), 0);
    check("rst_out_chan", int'(out_chan0), 0);
    rst = 1'b0;
    tick();

    // all ones, zero bias; stray start while busy
    load(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
    run_pass(4, 4, 4, 4, 0, 1'b1);

    // positive overflow saturates
    load(127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127);
    run_pass(127, 127, 127, 127, 0, 1'b0);

    // negative overflow saturates (chan 0), positive overflow (chan 1)
    load(-128, -128, -128, -128, 127, 127, 127, 127, -127, -127, -127, -127, 0, 0);
    run_pass(-128, 127, 0, 127, 0, 1'b0);

    // small negative result: -8+3=-5, -8+10=2
    load(1, 1, 1, 1, -2, -2, -2, -2, -2, -2, -2, -2, 3, 10);
    run_pass(-5, 2, 0, 2, 0, 1'b0);

    // mixed data with 10-cycle backpressure on chan 0: 10+5=15, 11-6=5
    load(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, -1, 3, 5, -6);
    run_pass(15, 5, 15, 5, 10, 1'b0);

    // reset during the second ISSUE cycle abandons the pass
    load(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
    begin
      int base;
      base = hs_count;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", int'(busy0), 0);
      check("abort_valid", int'(out_valid0), 0);
      check("abort_wt_addr", int'(wt_addr0), 0);
      repeat (12) tick();
      check("abort_no_result", hs_count - base, 0);
      check("abort_idle_valid", int'(out_valid0), 0);
    end
    run_pass(4, 4, 4, 4, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
